// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N_CH valid/ready input channels and one
// registered valid/ready output. "master" is the producer/consumer side, "slave" the mux.
interface stream_mux_rr_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(N_CH);

   logic [N_CH-1:0]       in_valid;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_ready;
   logic [CW-1:0]         sel;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [CW-1:0]         out_ch;
   logic                  out_ready;

   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N-channel stream multiplexer: round-robin or external-select grant,
// sliced N_CH:1 datapath, and a one-deep output register with valid/ready.
module stream_mux_rr #(
   parameter int N_CH    = 4,
   parameter int WIDTH   = 8,
   parameter int SLICE_W = 2,
   parameter int MODE    = 1
) (
   input logic            clk,
   input logic            rst,
   stream_mux_rr_if.slave bus
);
   localparam int CW  = $clog2(N_CH);
   localparam int PW  = 1 << CW;
   localparam int NSL = WIDTH / SLICE_W;

   if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
      $error("stream_mux_rr: N_CH must be in 2..16");
   end
   if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("stream_mux_rr: WIDTH must be a multiple of SLICE_W");
   end

   logic [CW-1:0]    ptr;
   logic             load_en;
   logic             grant_valid;
   logic [CW-1:0]    grant_idx;
   logic [CW:0]      cand;
   logic [PW-1:0]    valid_pad;
   logic [PW-1:0]    ready_pad;
   logic [WIDTH-1:0] sel_word;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [CW-1:0]    out_ch_q;

   // Padding to a power of two keeps every index into the valid/ready vectors in range.
   assign valid_pad = PW'(bus.in_valid);
   assign load_en   = !out_valid_q || bus.out_ready;

   // Round-robin scans ptr+1, ptr+2, ... wrapping at N_CH; external mode just qualifies sel.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (MODE == 1) begin
         for (int off = 1; off <= N_CH; off++) begin
            cand = {1'b0, ptr} + (CW+1)'(off);
            if (cand >= (CW+1)'(N_CH)) begin
               cand = cand - (CW+1)'(N_CH);
            end
            if (!grant_valid && valid_pad[cand[CW-1:0]]) begin
               grant_valid = 1'b1;
               grant_idx   = cand[CW-1:0];
            end
         end
      end else if (({1'b0, bus.sel} < (CW+1)'(N_CH)) && valid_pad[bus.sel]) begin
         grant_valid = 1'b1;
         grant_idx   = bus.sel;
      end
   end

   always_comb begin
      ready_pad = '0;
      if (load_en && grant_valid && !rst) begin
         ready_pad[grant_idx] = 1'b1;
      end
   end

   assign bus.in_ready = ready_pad[N_CH-1:0];

   for (genvar k = 0; k < NSL; k++) begin : g_slice
      logic [SLICE_W-1:0] slice_mux;

      always_comb begin
         slice_mux = '0;
         for (int c = 0; c < N_CH; c++) begin
            if (grant_idx == CW'(c)) begin
               slice_mux = bus.in_data[c*WIDTH + k*SLICE_W +: SLICE_W];
            end
         end
      end

      assign sel_word[k*SLICE_W +: SLICE_W] = slice_mux;
   end

   // ptr only moves on a completed transfer, so priority is frozen while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr         <= CW'(N_CH - 1);
      end else if (load_en) begin
         if (grant_valid) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_word;
            out_ch_q    <= grant_idx;
            if (MODE == 1) begin
               ptr <= grant_idx;
            end
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed round-robin/backpressure/reset sequences, a MODE 0
// vector table, and random traffic on four configurations against a behavioural model.
module tb_stream_mux_rr;
   localparam int ND = 4;
   localparam int NCH   [ND] = '{4, 4, 3, 3};
   localparam int WID   [ND] = '{8, 8, 12, 6};
   localparam int MODEP [ND] = '{1, 0, 1, 0};
   localparam int SELMAX[ND] = '{0, 3, 0, 3};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.N_CH(4), .WIDTH(8))  a_bus ();
   stream_mux_rr_if #(.N_CH(4), .WIDTH(8))  b_bus ();
   stream_mux_rr_if #(.N_CH(3), .WIDTH(12)) c_bus ();
   stream_mux_rr_if #(.N_CH(3), .WIDTH(6))  d_bus ();

   stream_mux_rr #(.N_CH(4), .WIDTH(8),  .SLICE_W(2), .MODE(1)) dut_a (.clk(clk), .rst(rst), .bus(a_bus));
   stream_mux_rr #(.N_CH(4), .WIDTH(8),  .SLICE_W(2), .MODE(0)) dut_b (.clk(clk), .rst(rst), .bus(b_bus));
   stream_mux_rr #(.N_CH(3), .WIDTH(12), .SLICE_W(4), .MODE(1)) dut_c (.clk(clk), .rst(rst), .bus(c_bus));
   stream_mux_rr #(.N_CH(3), .WIDTH(6),  .SLICE_W(3), .MODE(0)) dut_d (.clk(clk), .rst(rst), .bus(d_bus));

   int vectors = 0;
   int miscompares = 0;

   logic        tvld [ND][16];
   logic [31:0] tdat [ND][16];
   logic        trdy [ND];
   int          tsel [ND];

   logic        m_valid [ND];
   logic [31:0] m_data  [ND];
   int          m_ch    [ND];
   int          m_ptr   [ND];

   typedef struct packed {
      logic [3:0] vld;
      logic [1:0] sel;
      logic       rdy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_od;
      logic [1:0] exp_ch;
   } vec_t;

   vec_t vtab [6];

   task automatic applyStimulus();
      for (int i = 0; i < 4; i++) begin
         a_bus.in_valid[i]        = tvld[0][i];
         a_bus.in_data[i*8 +: 8]  = tdat[0][i][7:0];
         b_bus.in_valid[i]        = tvld[1][i];
         b_bus.in_data[i*8 +: 8]  = tdat[1][i][7:0];
      end
      for (int i = 0; i < 3; i++) begin
         c_bus.in_valid[i]         = tvld[2][i];
         c_bus.in_data[i*12 +: 12] = tdat[2][i][11:0];
         d_bus.in_valid[i]         = tvld[3][i];
         d_bus.in_data[i*6 +: 6]   = tdat[3][i][5:0];
      end
      a_bus.out_ready = trdy[0];
      b_bus.out_ready = trdy[1];
      c_bus.out_ready = trdy[2];
      d_bus.out_ready = trdy[3];
      a_bus.sel = 2'(tsel[0]);
      b_bus.sel = 2'(tsel[1]);
      c_bus.sel = 2'(tsel[2]);
      d_bus.sel = 2'(tsel[3]);
   endtask

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] dutReady(int d);
      case (d)
         0:       return 32'(a_bus.in_ready);
         1:       return 32'(b_bus.in_ready);
         2:       return 32'(c_bus.in_ready);
         default: return 32'(d_bus.in_ready);
      endcase
   endfunction

   function automatic logic [31:0] dutOv(int d);
      case (d)
         0:       return 32'(a_bus.out_valid);
         1:       return 32'(b_bus.out_valid);
         2:       return 32'(c_bus.out_valid);
         default: return 32'(d_bus.out_valid);
      endcase
   endfunction

   function automatic logic [31:0] dutOd(int d);
      case (d)
         0:       return 32'(a_bus.out_data);
         1:       return 32'(b_bus.out_data);
         2:       return 32'(c_bus.out_data);
         default: return 32'(d_bus.out_data);
      endcase
   endfunction

   function automatic logic [31:0] dutOch(int d);
      case (d)
         0:       return 32'(a_bus.out_ch);
         1:       return 32'(b_bus.out_ch);
         2:       return 32'(c_bus.out_ch);
         default: return 32'(d_bus.out_ch);
      endcase
   endfunction

   function automatic logic [31:0] dataMask(int d);
      return 32'((64'd1 << WID[d]) - 64'd1);
   endfunction

   // Reference grant: first valid channel cyclically after the last winner, or a qualified sel.
   function automatic int modelGrant(int d);
      int g = -1;
      if (MODEP[d] == 1) begin
         for (int k = 1; k <= NCH[d]; k++) begin
            int c = (m_ptr[d] + k) % NCH[d];
            if (g < 0 && tvld[d][c]) g = c;
         end
      end else if (tsel[d] < NCH[d] && tvld[d][tsel[d]]) begin
         g = tsel[d];
      end
      return g;
   endfunction

   task automatic clearInputs();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 16; i++) begin
            tvld[d][i] = 1'b0;
            tdat[d][i] = 32'd0;
         end
         trdy[d] = 1'b0;
         tsel[d] = 0;
      end
      applyStimulus();
   endtask

   task automatic doReset();
      rst = 1'b1;
      for (int d = 0; d < ND; d++) begin
         m_valid[d] = 1'b0;
         m_data[d]  = 32'd0;
         m_ch[d]    = 0;
         m_ptr[d]   = NCH[d] - 1;
      end
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   task automatic stepA(string tag, logic [3:0] vld, logic rdy, logic [3:0] exp_rdy,
                        logic exp_ov, logic [7:0] exp_od, logic [1:0] exp_ch);
      for (int i = 0; i < 4; i++) tvld[0][i] = vld[i];
      trdy[0] = rdy;
      applyStimulus();
      #1;
      checkOutput({tag, " in_ready"}, dutReady(0), 32'(exp_rdy));
      @(posedge clk);
      #1;
      checkOutput({tag, " out_valid"}, dutOv(0), 32'(exp_ov));
      checkOutput({tag, " out_data"}, dutOd(0), 32'(exp_od));
      checkOutput({tag, " out_ch"}, dutOch(0), 32'(exp_ch));
   endtask

   task automatic randomCycle(int cyc);
      int   g  [ND];
      logic le [ND];
      applyStimulus();
      #1;
      for (int d = 0; d < ND; d++) begin
         g[d]  = modelGrant(d);
         le[d] = !m_valid[d] || trdy[d];
         checkOutput($sformatf("rand c%0d d%0d in_ready", cyc, d), dutReady(d),
                     (le[d] && g[d] >= 0) ? (32'd1 << g[d]) : 32'd0);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         if (le[d]) begin
            if (g[d] >= 0) begin
               m_valid[d] = 1'b1;
               m_data[d]  = tdat[d][g[d]];
               m_ch[d]    = g[d];
               if (MODEP[d] == 1) m_ptr[d] = g[d];
            end else begin
               m_valid[d] = 1'b0;
            end
         end
         checkOutput($sformatf("rand c%0d d%0d out_valid", cyc, d), dutOv(d), 32'(m_valid[d]));
         checkOutput($sformatf("rand c%0d d%0d out_data", cyc, d), dutOd(d), m_data[d]);
         checkOutput($sformatf("rand c%0d d%0d out_ch", cyc, d), dutOch(d), 32'(m_ch[d]));
         for (int i = 0; i < NCH[d]; i++) begin
            if ((le[d] && g[d] == i) || !tvld[d][i]) begin
               tvld[d][i] = 1'($urandom_range(0, 1));
               tdat[d][i] = $urandom & dataMask(d);
            end
         end
         trdy[d] = ($urandom_range(0, 3) != 0);
         tsel[d] = $urandom_range(0, SELMAX[d]);
      end
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      doReset();

      // Round-robin, sparse grant, backpressure, idle and asynchronous reset on config A.
      for (int i = 0; i < 4; i++) tdat[0][i] = 32'hA0 + 32'(i);
      stepA("rr0", 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
      stepA("rr1", 4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
      stepA("rr2", 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
      stepA("rr3", 4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
      stepA("rr4", 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
      stepA("rr5", 4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
      stepA("sp0", 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
      stepA("sp1", 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
      stepA("sp2", 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
      for (int s = 0; s < 5; s++) begin
         stepA($sformatf("stall%0d", s), 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3);
      end
      stepA("release", 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
      stepA("idle",    4'h0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0);
      stepA("pre_rst", 4'hF, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst out_valid", dutOv(0), 32'd0);
      checkOutput("async_rst out_data", dutOd(0), 32'd0);
      checkOutput("async_rst out_ch", dutOch(0), 32'd0);
      checkOutput("async_rst in_ready", dutReady(0), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      stepA("post_rst", 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);

      // External select on config B, then every channel selected with random data.
      clearInputs();
      doReset();
      tdat[1][0] = 32'h11;
      tdat[1][1] = 32'h22;
      tdat[1][2] = 32'h5C;
      tdat[1][3] = 32'h44;
      vtab[0] = '{4'b0101, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2};
      vtab[1] = '{4'b0101, 2'd1, 1'b1, 4'b0000, 1'b0, 8'h5C, 2'd2};
      vtab[2] = '{4'b1111, 2'd3, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
      vtab[3] = '{4'b1111, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
      vtab[4] = '{4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vtab[5] = '{4'b0000, 2'd1, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) tvld[1][i] = vtab[v].vld[i];
         tsel[1] = int'(vtab[v].sel);
         trdy[1] = vtab[v].rdy;
         applyStimulus();
         #1;
         checkOutput($sformatf("tab%0d in_ready", v), dutReady(1), 32'(vtab[v].exp_rdy));
         @(posedge clk);
         #1;
         checkOutput($sformatf("tab%0d out_valid", v), dutOv(1), 32'(vtab[v].exp_ov));
         checkOutput($sformatf("tab%0d out_data", v), dutOd(1), 32'(vtab[v].exp_od));
         checkOutput($sformatf("tab%0d out_ch", v), dutOch(1), 32'(vtab[v].exp_ch));
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            tvld[1][i] = 1'b1;
            tdat[1][i] = $urandom & 32'hFF;
         end
         tsel[1] = c;
         trdy[1] = 1'b1;
         applyStimulus();
         #1;
         checkOutput($sformatf("slice%0d in_ready", c), dutReady(1), 32'd1 << c);
         @(posedge clk);
         #1;
         checkOutput($sformatf("slice%0d out_data", c), dutOd(1), tdat[1][c]);
         checkOutput($sformatf("slice%0d out_ch", c), dutOch(1), 32'(c));
      end

      // Random producers that honour valid/ready, all four configurations in parallel.
      clearInputs();
      doReset();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < NCH[d]; i++) begin
            tvld[d][i] = 1'($urandom_range(0, 1));
            tdat[d][i] = $urandom & dataMask(d);
         end
         trdy[d] = ($urandom_range(0, 3) != 0);
         tsel[d] = $urandom_range(0, SELMAX[d]);
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         randomCycle(cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
